// File: rtl/edge_pulse_gen.sv
// ---------------------------------------------------------------------------
// edge_pulse_gen
//
// Multi-channel edge-to-pulse converter. Each channel watches one level input,
// detects rising, falling or both edges (shared mode), and emits a
// programmable-width, retriggerable pulse. It also counts qualifying edges in
// a saturating counter.
//
// Optional feature macro: EDGE_PULSE_SYNC_EN
//   defined     - each x bit passes through a two-flop synchronizer (reset to 0)
//                 before edge detection; latency rises by 2 cycles.
//   not defined - x is used directly (inputs already synchronous to clk).
//
// Ports:
//   clk      in   clock
//   reset    in   synchronous, active-high reset
//   x        in   [CH]        level inputs, one bit per channel
//   mode     in   [2]         00 rising, 01 falling, 10 both, 11 disabled
//   pw       in   [PW_W]      pulse length in cycles (0 treated as 1)
//   clr_cnt  in   synchronous clear of all edge counters (wins over increment)
//   det      out  [CH]        per-channel pulse output (1 only in PULSE)
//   cnt      out  [CH*CNT_W]  per-channel edge counters, ch i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module edge_pulse_gen #(
    parameter int CH    = 4,
    parameter int PW_W  = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [CH-1:0]         x,
    input  logic [1:0]            mode,
    input  logic [PW_W-1:0]       pw,
    input  logic                  clr_cnt,
    output logic [CH-1:0]         det,
    output logic [CH*CNT_W-1:0]   cnt
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_LOW   = 2'd1,
        ST_HIGH  = 2'd2,
        ST_PULSE = 2'd3
    } state_t;

    logic [CH-1:0]   w_xs;
    logic [PW_W-1:0] w_pw_m1;

`ifdef EDGE_PULSE_SYNC_EN
    logic [CH-1:0] r_sync1;
    logic [CH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= x;
            r_sync2 <= r_sync1;
        end
    end

    assign w_xs = r_sync2;
`else
    assign w_xs = x;
`endif

    // Reload value for the down-counter: max(pw,1)-1, shared by all channels.
    assign w_pw_m1 = (pw == '0) ? '0 : (pw - PW_W'(1));

    genvar gi;
    generate
        for (gi = 0; gi < CH; gi++) begin : g_ch
            state_t           r_state;
            logic             r_level;
            logic [PW_W-1:0]  r_rem;
            logic             r_det;
            logic [CNT_W-1:0] r_cnt;
            logic             w_edge;
            logic             w_qual;
            state_t           w_settle;

            // INIT has no valid level yet, so it never reports an edge.
            assign w_edge   = (r_state != ST_INIT) && (w_xs[gi] != r_level);
            assign w_settle = w_xs[gi] ? ST_HIGH : ST_LOW;

            always_comb begin
                w_qual = 1'b0;
                case (mode)
                    2'b00:   w_qual = w_edge &  w_xs[gi];
                    2'b01:   w_qual = w_edge & ~w_xs[gi];
                    2'b10:   w_qual = w_edge;
                    default: w_qual = 1'b0;
                endcase
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_state <= ST_INIT;
                    r_level <= 1'b0;
                    r_rem   <= '0;
                    r_det   <= 1'b0;
                end else begin
                    // Level is tracked in every state, including PULSE.
                    r_level <= w_xs[gi];
                    case (r_state)
                        ST_INIT: begin
                            r_state <= w_settle;
                            r_det   <= 1'b0;
                        end
                        ST_LOW, ST_HIGH: begin
                            if (w_qual) begin
                                r_state <= ST_PULSE;
                                r_rem   <= w_pw_m1;
                                r_det   <= 1'b1;
                            end else begin
                                r_state <= w_settle;
                                r_det   <= 1'b0;
                            end
                        end
                        ST_PULSE: begin
                            if (mode == 2'b11) begin
                                // Disabled mode aborts a running pulse.
                                r_state <= w_settle;
                                r_rem   <= '0;
                                r_det   <= 1'b0;
                            end else if (w_qual) begin
                                r_rem   <= w_pw_m1;
                                r_det   <= 1'b1;
                            end else if (r_rem == '0) begin
                                r_state <= w_settle;
                                r_det   <= 1'b0;
                            end else begin
                                r_rem   <= r_rem - PW_W'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_INIT;
                            r_det   <= 1'b0;
                        end
                    endcase
                end
            end

            // Saturating edge counter; clear takes priority over an increment.
            always_ff @(posedge clk) begin
                if (reset || clr_cnt) begin
                    r_cnt <= '0;
                end else if (w_qual && (r_cnt != {CNT_W{1'b1}})) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            assign det[gi]                   = r_det;
            assign cnt[gi*CNT_W +: CNT_W]    = r_cnt;
        end
    endgenerate

endmodule

// File: tb/tb_edge_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_edge_pulse_gen
//
// Directed stimulus for edge_pulse_gen. A cycle-count model (remaining pulse
// cycles, edge count per channel) predicts det/cnt; outputs are compared on
// every negedge, and literal expectations pin the key scenarios.
// ---------------------------------------------------------------------------
module tb_edge_pulse_gen;
    localparam int CH    = 4;
    localparam int PW_W  = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic [CH-1:0]       x;
    logic [1:0]          mode;
    logic [PW_W-1:0]     pw;
    logic                clr_cnt;
    logic [CH-1:0]       det;
    logic [CH*CNT_W-1:0] cnt;

    always #5 clk = ~clk;

    edge_pulse_gen #(.CH(CH), .PW_W(PW_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .x       (x),
        .mode    (mode),
        .pw      (pw),
        .clr_cnt (clr_cnt),
        .det     (det),
        .cnt     (cnt)
    );

    int vectors     = 0;
    int miscompares = 0;

    // ---------------- behavioural model ----------------
    int m_left [CH];   // pulse cycles still to be shown
    int m_cnt  [CH];
    bit m_known[CH];
    bit m_level[CH];
    bit m_s1   [CH];
    bit m_s2   [CH];
    bit model_valid = 1'b0;

    always @(posedge clk) begin : model
        bit xs;
        bit e;
        bit q;
        int plen;
        if (reset) begin
            for (int c = 0; c < CH; c++) begin
                m_left[c]  = 0;
                m_cnt[c]   = 0;
                m_known[c] = 1'b0;
                m_level[c] = 1'b0;
                m_s1[c]    = 1'b0;
                m_s2[c]    = 1'b0;
            end
            model_valid = 1'b1;
        end else begin
            plen = (pw == 0) ? 1 : int'(pw);
            for (int c = 0; c < CH; c++) begin
`ifdef EDGE_PULSE_SYNC_EN
                xs      = m_s2[c];
                m_s2[c] = m_s1[c];
                m_s1[c] = x[c];
`else
                xs = x[c];
`endif
                if (!m_known[c]) begin
                    m_known[c] = 1'b1;
                end else begin
                    e = (xs != m_level[c]);
                    q = e && ((mode == 2'b00 && xs) || (mode == 2'b01 && !xs) ||
                              (mode == 2'b10));
                    if (q) begin
                        m_left[c] = plen;
                        if (m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
                    end else if (mode == 2'b11) begin
                        m_left[c] = 0;
                    end else if (m_left[c] > 0) begin
                        m_left[c] = m_left[c] - 1;
                    end
                end
                m_level[c] = xs;
                if (clr_cnt) m_cnt[c] = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int hi_cnt[CH];

    task automatic cycle_check();
        logic [CH-1:0]       exp_det;
        logic [CH*CNT_W-1:0] exp_cnt;
        if (!model_valid) return;
        for (int c = 0; c < CH; c++) begin
            exp_det[c]                = (m_left[c] > 0);
            exp_cnt[c*CNT_W +: CNT_W] = CNT_W'(m_cnt[c]);
        end
        vectors++;
        if (det !== exp_det || cnt !== exp_cnt) begin
            miscompares++;
            $display("FAIL cycle t=%0t det=%h exp %h cnt=%h exp %h",
                     $time, det, exp_det, cnt, exp_cnt);
        end
        for (int c = 0; c < CH; c++)
            if (det[c] === 1'b1) hi_cnt[c]++;
    endtask

    // Advance n cycles: compare at negedge, return #1 after posedge.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            cycle_check();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    function automatic int cnt_of(input int c);
        return int'(cnt[c*CNT_W +: CNT_W]);
    endfunction

    int base;

    initial begin
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        reset   = 1'b1;
        x       = '1;
        mode    = 2'b00;
        pw      = '0;
        clr_cnt = 1'b0;
        step(2);
        check("reset_det", int'(det), 0);
        check("reset_cnt0", cnt_of(0), 0);

        // Post-reset level: x held high must not look like an edge.
        reset = 1'b0;
        step(10);
`ifndef EDGE_PULSE_SYNC_EN
        check("postreset_hi0", hi_cnt[0], 0);
        check("postreset_cnt0", cnt_of(0), 0);
`endif

        // Rising edge, pw=3; falling edges are ignored in mode 00.
        x = '0;
        step(3);
        pw   = 4'd3;
        base = hi_cnt[0];
        x[0] = 1'b1;
        step(8);
        check("rise_len", hi_cnt[0] - base, 3);
        check("rise_cnt0", cnt_of(0), 1);
        x[0] = 1'b0;
        step(6);
        check("fall_nopulse", hi_cnt[0] - base, 3);

        // Both edges, pw=0 -> 1-cycle pulses.
        mode = 2'b10;
        pw   = 4'd0;
        base = hi_cnt[1];
        for (int i = 0; i < 4; i++) begin
            x[1] = ~x[1];
            step(4);
        end
        step(2);
        check("both_len", hi_cnt[1] - base, 4);
        check("both_cnt1", cnt_of(1), 4);
        check("both_cnt2", cnt_of(2), 0);
        check("both_cnt3", cnt_of(3), 0);

        // Retrigger: pw=5, second edge 2 cycles later -> 7 cycles.
        pw   = 4'd5;
        base = hi_cnt[2];
        x[2] = 1'b1;
        step(2);
        x[2] = 1'b0;
        step(12);
        check("retrig_len", hi_cnt[2] - base, 7);
        check("retrig_cnt2", cnt_of(2), 2);

        // Saturation: 300 rising edges on ch0.
        mode = 2'b00;
        pw   = 4'd1;
        for (int i = 0; i < 300; i++) begin
            x[0] = 1'b1;
            step(1);
            x[0] = 1'b0;
            step(1);
        end
        step(4);
        check("sat_cnt0", cnt_of(0), 255);

        // Clear coincident with an edge.
        x[0]    = 1'b1;
        clr_cnt = 1'b1;
        step(1);
        clr_cnt = 1'b0;
`ifndef EDGE_PULSE_SYNC_EN
        check("clr_cnt0", cnt_of(0), 0);
        check("clr_det0", int'(det[0]), 1);
`endif
        x[0] = 1'b0;
        step(4);

        // Abort via mode 11.
        pw   = 4'd15;
        x[3] = 1'b1;
        step(3);
        check("abort_pre_det3", int'(det[3]), 1);
        mode = 2'b11;
        step(1);
        check("abort_det3", int'(det[3]), 0);
        step(2);
        mode = 2'b00;
        x[3] = 1'b0;
        step(4);

        // Reset mid-pulse.
        x[3] = 1'b1;
        step(4);
        check("rst_pre_det3", int'(det[3]), 1);
        reset = 1'b1;
        step(1);
        check("rst_det", int'(det), 0);
        check("rst_cnt", (cnt == '0) ? 1 : 0, 1);
        reset = 1'b0;
        step(6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
